// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
//   Registered bitwise logic unit with a single-stage valid/ready output
//   register, zero/parity flags on the held result and a saturating count of
//   completed output handshakes.
//
// Ports
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  operand stream handshake (in_ready is combinational)
//   in_op, in_a, in_b    opcode and WIDTH-bit operands, sampled on accept
//   out_valid/out_ready  result stream handshake
//   out_y                registered result
//   out_zero, out_parity registered flags of out_y
//   clr_count            synchronous clear of txn_count (wins over an emit)
//   txn_count            saturating count of output handshakes
// -----------------------------------------------------------------------------
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_parity,
    input  logic             clr_count,
    output logic [CNT_W-1:0] txn_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic             parity_q, parity_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] res_c;
    logic             accept_c;
    logic             emit_c;

    // Bitwise operation selected by the opcode
    always_comb begin
        res_c = '0;
        unique case (in_op)
            3'd0: res_c = ~in_a;
            3'd1: res_c = in_a & in_b;
            3'd2: res_c = in_a | in_b;
            3'd3: res_c = ~(in_a & in_b);
            3'd4: res_c = ~(in_a | in_b);
            3'd5: res_c = in_a ^ in_b;
            3'd6: res_c = ~(in_a ^ in_b);
            3'd7: res_c = in_a;
            default: res_c = '0;
        endcase
    end

    // A slot is free when empty or when the held result leaves this cycle
    assign in_ready  = (state_q == S_EMPTY) || out_ready;
    assign out_valid = (state_q == S_FULL);
    assign accept_c  = in_valid && in_ready;
    assign emit_c    = out_valid && out_ready;

    // Next-state, result capture and counter update
    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        zero_d   = zero_q;
        parity_d = parity_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            S_EMPTY: if (accept_c) state_d = S_FULL;
            S_FULL:  if (emit_c && !accept_c) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase

        // Result and flags only change on accept; an emit alone keeps them
        if (accept_c) begin
            y_d      = res_c;
            zero_d   = (res_c == '0);
            parity_d = ^res_c;
        end

        if (clr_count) begin
            cnt_d = '0;
        end else if (emit_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_EMPTY;
            y_q      <= '0;
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            zero_q   <= zero_d;
            parity_q <= parity_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_y      = y_q;
    assign out_zero   = zero_q;
    assign out_parity = parity_q;
    assign txn_count  = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_pipe
//   Directed and randomized bench for logic_unit_pipe (WIDTH=8, CNT_W=4),
//   comparing against a cycle-level behavioural model of the stream rules.
// -----------------------------------------------------------------------------
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic       out_zero;
    logic       out_parity;
    logic       clr_count;
    logic [3:0] txn_count;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    bit       m_valid;
    bit [7:0] m_y;
    bit       m_zero;
    bit       m_par;
    int       m_cnt;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_zero   (out_zero),
        .out_parity (out_parity),
        .clr_count  (clr_count),
        .txn_count  (txn_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit [7:0] ref_op(input int op, input bit [7:0] a, input bit [7:0] b);
        case (op)
            0: return ~a;
            1: return a & b;
            2: return a | b;
            3: return ~(a & b);
            4: return ~(a | b);
            5: return a ^ b;
            6: return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_y = 8'h00; m_zero = 0; m_par = 0; m_cnt = 0;
    endtask

    // One clock with the currently driven inputs; model advances alongside
    task automatic tick();
        bit rdy, acc, emit;
        #2;
        rdy  = !m_valid || (out_ready === 1'b1);
        check("in_ready", 32'(in_ready), 32'(rdy));
        acc  = (in_valid === 1'b1) && rdy;
        emit = m_valid && (out_ready === 1'b1);
        @(posedge clk);
        #1;
        if (clr_count === 1'b1) m_cnt = 0;
        else if (emit && m_cnt < 15) m_cnt = m_cnt + 1;
        if (acc) begin
            m_y     = ref_op(int'(in_op), in_a, in_b);
            m_zero  = (m_y == 0);
            m_par   = ($countones(m_y) % 2) == 1;
            m_valid = 1;
        end else if (emit) begin
            m_valid = 0;
        end
        check("out_valid",  32'(out_valid),  32'(m_valid));
        check("out_y",      32'(out_y),      32'(m_y));
        check("out_zero",   32'(out_zero),   32'(m_zero));
        check("out_parity", 32'(out_parity), 32'(m_par));
        check("txn_count",  32'(txn_count),  32'(m_cnt));
    endtask

    task automatic drive(input bit v, input bit [2:0] op, input bit [7:0] a,
                         input bit [7:0] b, input bit ordy, input bit clr);
        in_valid = v; in_op = op; in_a = a; in_b = b; out_ready = ordy; clr_count = clr;
    endtask

    initial begin
        bit [7:0] sweep_exp [8];
        int       cnt_before;
        sweep_exp = '{8'h3C, 8'h81, 8'hE7, 8'h7E, 8'h18, 8'h66, 8'h99, 8'hC3};

        // Reset values
        rst = 1'b1;
        drive(0, 3'd0, 8'h00, 8'h00, 0, 0);
        model_reset();
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_y",     32'(out_y),     32'd0);
        check("rst_txn_count", 32'(txn_count), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Op sweep with fixed operands, consumer always ready
        for (int op = 0; op < 8; op++) begin
            drive(1, 3'(op), 8'hC3, 8'hA5, 1, 0);
            tick();
            check($sformatf("sweep_y_op%0d", op), 32'(out_y), 32'(sweep_exp[op]));
        end
        drive(0, 3'd0, 8'h00, 8'h00, 1, 0);
        tick();

        // Backpressure: held result stays stable and no new accept
        drive(1, 3'd5, 8'hFF, 8'hFF, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'd2, 8'h12, 8'h34, 0, 0);
            tick();
            check("bp_y",     32'(out_y),     32'h00);
            check("bp_zero",  32'(out_zero),  32'd1);
            check("bp_valid", 32'(out_valid), 32'd1);
        end
        cnt_before = int'(txn_count);
        drive(0, 3'd0, 8'h00, 8'h00, 1, 0);
        tick();
        check("bp_emit_cnt", 32'(txn_count), 32'(cnt_before + 1));

        // Throughput: one result per cycle
        drive(0, 3'd0, 8'h00, 8'h00, 1, 1);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1, 3'd7, 8'(i), 8'hFF, 1, 0);
            tick();
            check("tp_y", 32'(out_y), 32'(i));
        end
        drive(0, 3'd0, 8'h00, 8'h00, 1, 0);
        tick();
        check("tp_count", 32'(txn_count), 32'd10);

        // Saturation then clear coinciding with an emit
        for (int i = 0; i < 21; i++) begin
            drive(1, 3'(i), 8'(i * 7), 8'(i * 3), 1, 0);
            tick();
        end
        check("sat_count", 32'(txn_count), 32'd15);
        drive(1, 3'd1, 8'hAA, 8'h0F, 1, 1);
        tick();
        check("clr_count", 32'(txn_count), 32'd0);

        // Async reset while FULL and stalled, asserted between edges
        drive(1, 3'd3, 8'h5A, 8'hF0, 0, 0);
        tick();
        drive(0, 3'd0, 8'h00, 8'h00, 0, 0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_valid",    32'(out_valid), 32'd0);
        check("arst_y",        32'(out_y),     32'd0);
        check("arst_count",    32'(txn_count), 32'd0);
        check("arst_in_ready", 32'(in_ready),  32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1, 3'd0, 8'hC3, 8'hA5, 1, 0);
        tick();
        check("post_rst_y", 32'(out_y), 32'h3C);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                  8'($urandom), 8'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 31) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
